sha1_single_block: RTL
======================

SHA1_SINGLE_BLOCK -- requirements
Module: sha1_single_block

Interface
REQ-001 The module SHALL have parameter MSG_BITS, default 144, giving the message width (KDF z plus 16-bit counter); legal range is 8..447, a multiple of 8.
REQ-002 The module SHALL have parameter HASH_SIZE, default 160, giving the digest width; only 160 is supported.
REQ-003 The module SHALL have port clk  input  1  rising-edge clock; it is the single clock.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port hashGo  input  1  start request, sampled on a rising clk edge.
REQ-006 The module SHALL have port msgIn  input  MSG_BITS  message, MSB = first message bit; captured only when a start is accepted.
REQ-007 The module SHALL have port hashReady  output  1  engine idle, able to accept hashGo.
REQ-008 The module SHALL have port hashDone  output  1  one-cycle pulse marking hashedOut as new.
REQ-009 The module SHALL have port hashedOut  output  HASH_SIZE  SHA-1 digest H0..H4, with H0 in the MSBs.

Function
REQ-010 The module SHALL implement FIPS 180-4 SHA-1 over exactly one 512-bit block, formed as {msgIn, 1'b1, zeros, 64-bit MSG_BITS}.
REQ-011 States SHALL be IDLE, ROUND and FINAL.
REQ-012 In IDLE, hashReady SHALL be 1; hashGo=1 at an edge SHALL do all of the following: capture the padded block into the 16-word schedule, load a..e with H0..H4 initial constants, clear the round counter t, enter ROUND, and drive hashReady to 0.
REQ-013 ROUND SHALL execute one round per cycle for t=0..79 using W[t]=ROTL1(W[t-3]^W[t-8]^W[t-14]^W[t-16]) from a rolling 16-word buffer, with f/K selected by t ranges 0-19, 20-39, 40-59 and 60-79.
REQ-014 After round 79, the machine SHALL enter FINAL.
REQ-015 FINAL SHALL register hashedOut = {H0+a, ..., H4+e}, with each sum taken mod 2^32.
REQ-016 FINAL SHALL pulse hashDone for exactly one cycle, set hashReady to 1 and return to IDLE, all on the same edge.
REQ-017 Latency: if the start is accepted at edge k, hashDone and the new hashedOut SHALL be visible after edge k+81; hashReady SHALL be low from after edge k until after edge k+81.
REQ-018 hashGo while hashReady=0 SHALL be ignored, with no queueing.
REQ-019 hashGo held high across the hashDone cycle SHALL start a new hash at the next edge (back-to-back operation; the KDF counter iteration depends on it).
REQ-020 hashedOut SHALL hold its value until the next FINAL.
REQ-021 msgIn changes after acceptance SHALL have no effect on the running hash.
REQ-022 The round counter SHALL be 7 bits, and t SHALL never exceed 79.

Reset
REQ-023 While rst=0, the module SHALL force state=IDLE, hashReady=1, hashDone=0, hashedOut=0, and clear t, a..e and the schedule.
REQ-024 Reset asserted mid-operation SHALL abort the hash with no hashDone pulse.
REQ-025 The first start after reset release SHALL behave per REQ-012.

Structure
REQ-026 A shared package ecies_pkg SHALL hold the SHA-1 initial constants H0..H4, the round constants K0..K3, the state enum, and ROUNDS=80.
REQ-027 The block SHALL contain one combinational sub-module, sha1_round, which takes a..e, W[t] and t and produces the next a..e.
REQ-028 The schedule and state registers SHALL live in sha1_single_block.

Verification
REQ-029 With MSG_BITS=24, msgIn="abc" (0x616263) and a hashGo pulse, the bench SHALL check hashedOut = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
REQ-030 At default MSG_BITS=144, a bench SHALL check 200 random msgIn values against a software SHA-1 model, and SHALL check that hashDone is high for exactly 1 cycle at 81 cycles after acceptance.
REQ-031 A bench SHALL pulse hashGo at cycles 10, 40 and 70 after acceptance and check that exactly one hashDone occurs and the digest matches the first msgIn.
REQ-032 A bench SHALL change msgIn every cycle during ROUND and check that the digest equals that of the captured message.
REQ-033 A bench SHALL assert rst low at round 50 and check hashReady=1, hashedOut=0 and no hashDone; the next hash SHALL then be correct.
REQ-034 A bench SHALL hold hashGo high continuously with msgIn counter fields 1,2,3 advanced on each hashDone, and check three digests spaced 82 cycles apart.

Source files
------------

// File: rtl/ecies_pkg.sv
`default_nettype none
// ============================================================================
// ecies_pkg : SHA-1 constants, round count and engine state encoding
// Revision  : 1.0
// ============================================================================
package ecies_pkg;

   localparam logic [31:0] c_h0 = 32'h6745_2301;
   localparam logic [31:0] c_h1 = 32'hEFCD_AB89;
   localparam logic [31:0] c_h2 = 32'h98BA_DCFE;
   localparam logic [31:0] c_h3 = 32'h1032_5476;
   localparam logic [31:0] c_h4 = 32'hC3D2_E1F0;

   localparam logic [31:0] c_k0 = 32'h5A82_7999;
   localparam logic [31:0] c_k1 = 32'h6ED9_EBA1;
   localparam logic [31:0] c_k2 = 32'h8F1B_BCDC;
   localparam logic [31:0] c_k3 = 32'hCA62_C1D6;

   localparam int c_rounds = 80;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } sha1_state_e;

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

endpackage
`default_nettype wire

// File: rtl/sha1_round.sv
`default_nettype none
// ============================================================================
// sha1_round : one combinational SHA-1 compression round
// Revision   : 1.0
// ============================================================================
module sha1_round
   import ecies_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [31:0] d,
   input  logic [31:0] e,
   input  logic [31:0] wt,
   input  logic [6:0]  t,
   output logic [31:0] a_nxt,
   output logic [31:0] b_nxt,
   output logic [31:0] c_nxt,
   output logic [31:0] d_nxt,
   output logic [31:0] e_nxt
);

   logic [31:0] w_f;
   logic [31:0] w_k;

   always_comb begin
      w_f = b ^ c ^ d;
      w_k = c_k3;
      if (t < 7'd20) begin
         w_f = (b & c) | (~b & d);
         w_k = c_k0;
      end else if (t < 7'd40) begin
         w_f = b ^ c ^ d;
         w_k = c_k1;
      end else if (t < 7'd60) begin
         w_f = (b & c) | (b & d) | (c & d);
         w_k = c_k2;
      end
   end

   assign a_nxt = rotl(a, 5) + w_f + e + w_k + wt;
   assign b_nxt = a;
   assign c_nxt = rotl(b, 30);
   assign d_nxt = c;
   assign e_nxt = d;

endmodule
`default_nettype wire

// File: rtl/sha1_single_block.sv
`default_nettype none
// ============================================================================
// sha1_single_block : SHA-1 over one padded 512-bit block, one round per clock
// Revision          : 1.0
// ============================================================================
module sha1_single_block
   import ecies_pkg::*;
#(
   parameter int MSG_BITS  = 144,
   parameter int HASH_SIZE = 160
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hashGo,
   input  logic [MSG_BITS-1:0]  msgIn,
   output logic                 hashReady,
   output logic                 hashDone,
   output logic [HASH_SIZE-1:0] hashedOut
);

   sha1_state_e          r_state;
   sha1_state_e          w_state_nxt;
   logic [6:0]           r_t;
   logic [31:0]          r_a, r_b, r_c, r_d, r_e;
   logic [31:0]          w_a_nxt, w_b_nxt, w_c_nxt, w_d_nxt, w_e_nxt;
   logic [31:0]          r_w [16];
   logic [31:0]          w_w_new;
   logic [511:0]         w_block;
   logic                 w_start;
   logic                 w_last_round;
   logic                 r_done;
   logic [HASH_SIZE-1:0] r_digest;

   // Single-block padding: message, a 1 bit, zero fill, 64-bit bit length.
   always_comb begin
      w_block                 = '0;
      w_block[511 -: MSG_BITS] = msgIn;
      w_block[511 - MSG_BITS] = 1'b1;
      w_block[63:0]           = 64'(MSG_BITS);
   end

   // r_w[0] always holds W[t]; the word entering at the top is W[t+16].
   assign w_w_new = rotl(r_w[13] ^ r_w[8] ^ r_w[2] ^ r_w[0], 1);

   sha1_round u_round (
      .a     (r_a),
      .b     (r_b),
      .c     (r_c),
      .d     (r_d),
      .e     (r_e),
      .wt    (r_w[0]),
      .t     (r_t),
      .a_nxt (w_a_nxt),
      .b_nxt (w_b_nxt),
      .c_nxt (w_c_nxt),
      .d_nxt (w_d_nxt),
      .e_nxt (w_e_nxt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_start)      w_state_nxt = S_ROUND;
         S_ROUND: if (w_last_round) w_state_nxt = S_FINAL;
         S_FINAL:                   w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      hashReady    = (r_state == S_IDLE);
      w_start      = hashReady & hashGo;
      w_last_round = (r_state == S_ROUND) && (r_t == 7'(c_rounds - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_t      <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_d      <= '0;
         r_e      <= '0;
         r_done   <= 1'b0;
         r_digest <= '0;
         for (int i = 0; i < 16; i++) r_w[i] <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  for (int i = 0; i < 16; i++) r_w[i] <= w_block[511 - 32*i -: 32];
                  r_a <= c_h0;
                  r_b <= c_h1;
                  r_c <= c_h2;
                  r_d <= c_h3;
                  r_e <= c_h4;
                  r_t <= '0;
               end
            end
            S_ROUND: begin
               r_a <= w_a_nxt;
               r_b <= w_b_nxt;
               r_c <= w_c_nxt;
               r_d <= w_d_nxt;
               r_e <= w_e_nxt;
               for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
               r_w[15] <= w_w_new;
               r_t     <= w_last_round ? 7'd0 : r_t + 7'd1;
            end
            S_FINAL: begin
               r_digest <= {c_h0 + r_a, c_h1 + r_b, c_h2 + r_c, c_h3 + r_d, c_h4 + r_e};
               r_done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign hashDone  = r_done;
   assign hashedOut = r_digest;

endmodule
`default_nettype wire
